// File: rtl/conf_pkg.sv
// Shared sorter configuration: sample/index/count types and eviction FSM states.
package conf_pkg;

  localparam int WINDOW_LENGTH = 8;
  localparam int UDATA_WIDTH   = 16;

  typedef logic [UDATA_WIDTH-1:0]                 udata_t;
  typedef logic [$clog2(WINDOW_LENGTH)-1:0]       window_t;
  typedef logic [$clog2(WINDOW_LENGTH + 1)-1:0]   count_t;

  localparam udata_t UDATA_MAX = '1;

  typedef enum logic {
    FILL,
    FULL
  } evict_state_e;

  // Age FIFO pointer step; depth may be smaller than the index type's range.
  function automatic window_t wrapInc(input window_t ptr, input int depth);
    return (int'(ptr) == depth - 1) ? '0 : window_t'(int'(ptr) + 1);
  endfunction

endpackage

// File: rtl/window_evict_if.sv
// Handshake and data bundle between the sorter core and the eviction block.
interface window_evict_if #(
  parameter int WL = conf_pkg::WINDOW_LENGTH
);
  import conf_pkg::*;

  logic    in_valid;
  logic    in_ready;
  udata_t  in_data;
  udata_t  sorted_buf [WL];
  logic    out_valid;
  logic    out_ready;
  logic    out_evict;
  window_t out_index;
  udata_t  out_data;
  udata_t  out_buf [WL-1];
  count_t  count;
  logic    err;

  modport master (
    output in_valid, in_data, sorted_buf, out_ready,
    input  in_ready, out_valid, out_evict, out_index, out_data, out_buf, count, err
  );

  modport slave (
    input  in_valid, in_data, sorted_buf, out_ready,
    output in_ready, out_valid, out_evict, out_index, out_data, out_buf, count, err
  );

endinterface

// File: rtl/remove_index.sv
// Combinational search for the lowest sorted-window slot equal to a value.
// The found flag exists only when EVICT_CHECK_EN is defined.
module remove_index
  import conf_pkg::*;
#(
  parameter int WL = WINDOW_LENGTH
) (
  input  udata_t  buffer [WL],
  input  udata_t  data,
  output window_t index
`ifdef EVICT_CHECK_EN
  ,
  output logic    found
`endif
);

  // Scan high to low so the lowest matching slot wins; no match leaves the last slot.
  always_comb begin
    index = window_t'(WL - 1);
`ifdef EVICT_CHECK_EN
    found = 1'b0;
`endif
    for (int j = WL - 1; j >= 0; j--) begin
      if (buffer[j] == data) begin
        index = window_t'(j);
`ifdef EVICT_CHECK_EN
        found = 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/window_evict.sv
// Sliding-window delete side: age FIFO, FILL/FULL FSM, compaction mux, output register.
// Define EVICT_CHECK_EN to flag (sticky err) an evicted value missing from sorted_buf.
module window_evict
  import conf_pkg::*;
#(
  parameter int WL = WINDOW_LENGTH
) (
  input logic           clk,
  input logic           rst,
  window_evict_if.slave bus
);

  evict_state_e r_state;
  evict_state_e w_next_state;

  udata_t  r_fifo [WINDOW_LENGTH];
  window_t r_rd_ptr;
  window_t r_wr_ptr;
  count_t  r_count;

  logic    r_out_valid;
  logic    r_out_evict;
  window_t r_out_index;
  udata_t  r_out_data;
  udata_t  r_out_buf [WL-1];
  logic    r_err;

  logic    w_accept;
  udata_t  w_oldest;
  window_t w_match_index;
  window_t w_sel_index;
  udata_t  w_buf [WL-1];

  assign bus.in_ready = !r_out_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_oldest     = r_fifo[r_rd_ptr];

`ifdef EVICT_CHECK_EN
  logic w_found;

  remove_index #(.WL(WL)) u_search (
    .buffer (bus.sorted_buf),
    .data   (w_oldest),
    .index  (w_match_index),
    .found  (w_found)
  );
`else
  remove_index #(.WL(WL)) u_search (
    .buffer (bus.sorted_buf),
    .data   (w_oldest),
    .index  (w_match_index)
  );
`endif

  // During fill nothing is removed, so the last slot (an empty UDATA_MAX) is dropped.
  assign w_sel_index = (r_state == FULL) ? w_match_index : window_t'(WL - 1);

  always_comb begin
    for (int k = 0; k < WL - 1; k++) begin
      w_buf[k] = (k < int'(w_sel_index)) ? bus.sorted_buf[k] : bus.sorted_buf[k+1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FILL: if (w_accept && (r_count == count_t'(WL - 1))) w_next_state = FULL;
      FULL: w_next_state = FULL;
      default: w_next_state = FILL;
    endcase
  end

  // In FULL the FIFO is always full, so every accept pops and pushes together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < WINDOW_LENGTH; i++) r_fifo[i] <= '0;
    end else if (w_accept) begin
      r_fifo[r_wr_ptr] <= bus.in_data;
      r_wr_ptr         <= wrapInc(r_wr_ptr, WL);
      if (r_state == FULL) r_rd_ptr <= wrapInc(r_rd_ptr, WL);
      else                 r_count  <= r_count + count_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_evict <= 1'b0;
      r_out_index <= '0;
      r_out_data  <= '0;
      for (int k = 0; k < WL - 1; k++) r_out_buf[k] <= UDATA_MAX;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_evict <= (r_state == FULL);
      r_out_index <= w_sel_index;
      r_out_data  <= (r_state == FULL) ? w_oldest : '0;
      for (int k = 0; k < WL - 1; k++) r_out_buf[k] <= w_buf[k];
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef EVICT_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            r_err <= 1'b0;
    else if (w_accept && (r_state == FULL) && !w_found) r_err <= 1'b1;
  end
`else
  assign r_err = 1'b0;
`endif

  assign bus.out_valid = r_out_valid;
  assign bus.out_evict = r_out_evict;
  assign bus.out_index = r_out_index;
  assign bus.out_data  = r_out_data;
  assign bus.out_buf   = r_out_buf;
  assign bus.count     = r_count;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_window_evict.sv
// Directed bench for window_evict at a window length of 4: fill, evict, duplicates,
// backpressure, mid-stream reset and the missing-value case (err follows EVICT_CHECK_EN).
module tb_window_evict;
  import conf_pkg::*;

  localparam int     WL = 4;
  localparam udata_t M  = UDATA_MAX;

`ifdef EVICT_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nChecks = 0;
  int   nPass   = 0;

  window_evict_if #(.WL(WL)) bus ();

  window_evict #(.WL(WL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Every comparison funnels through here so counts and report format stay uniform.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic checkOutput(input string tag, input logic evict, input int index,
                             input udata_t data, input udata_t b0, input udata_t b1,
                             input udata_t b2, input int cnt);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(1));
    chk({tag, ".evict"}, 32'(bus.out_evict), 32'(evict));
    chk({tag, ".index"}, 32'(bus.out_index), 32'(index));
    chk({tag, ".data"},  32'(bus.out_data),  32'(data));
    chk({tag, ".buf0"},  32'(bus.out_buf[0]), 32'(b0));
    chk({tag, ".buf1"},  32'(bus.out_buf[1]), 32'(b1));
    chk({tag, ".buf2"},  32'(bus.out_buf[2]), 32'(b2));
    chk({tag, ".count"}, 32'(bus.count),     32'(cnt));
  endtask

  // Offers one sample and returns 1 time unit after the edge that accepts it.
  task automatic applyStimulus(input string tag, input udata_t d, input udata_t s0,
                               input udata_t s1, input udata_t s2, input udata_t s3);
    bit accepted = 1'b0;
    bus.in_valid      = 1'b1;
    bus.in_data       = d;
    bus.sorted_buf[0] = s0;
    bus.sorted_buf[1] = s1;
    bus.sorted_buf[2] = s2;
    bus.sorted_buf[3] = s3;
    for (int c = 0; c < 20; c++) begin
      if (bus.in_ready) begin
        accepted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (accepted) begin
      @(posedge clk);
      #1;
    end else begin
      nChecks++;
      $display("[TB] FAIL %s.accept: in_ready never rose, observed=0 expected=1", tag);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < WL; i++) bus.sorted_buf[i] = M;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst.valid", 32'(bus.out_valid), 32'(0));
    chk("rst.evict", 32'(bus.out_evict), 32'(0));
    chk("rst.index", 32'(bus.out_index), 32'(0));
    chk("rst.data",  32'(bus.out_data),  32'(0));
    chk("rst.buf0",  32'(bus.out_buf[0]), 32'(M));
    chk("rst.buf2",  32'(bus.out_buf[2]), 32'(M));
    chk("rst.count", 32'(bus.count),     32'(0));
    chk("rst.err",   32'(bus.err),       32'(0));
    chk("rst.ready", 32'(bus.in_ready),  32'(1));

    applyStimulus("fill5", 5, M, M, M, M);
    checkOutput("fill5", 1'b0, 3, 0, M, M, M, 1);
    applyStimulus("fill2", 2, 5, M, M, M);
    checkOutput("fill2", 1'b0, 3, 0, 5, M, M, 2);
    applyStimulus("fill9", 9, 2, 5, M, M);
    checkOutput("fill9", 1'b0, 3, 0, 2, 5, M, 3);
    applyStimulus("fill7", 7, 2, 5, 9, M);
    checkOutput("fill7", 1'b0, 3, 0, 2, 5, 9, 4);

    applyStimulus("evict3", 3, 2, 5, 7, 9);
    checkOutput("evict3", 1'b1, 1, 5, 2, 7, 9, 4);

    applyStimulus("evict8", 8, 2, 3, 7, 9);
    checkOutput("evict8", 1'b1, 0, 2, 3, 7, 9, 4);

    // Hold the evict8 result for three cycles while 10 is already being offered.
    bus.out_ready     = 1'b0;
    bus.in_valid      = 1'b1;
    bus.in_data       = 10;
    bus.sorted_buf[0] = 3;
    bus.sorted_buf[1] = 7;
    bus.sorted_buf[2] = 8;
    bus.sorted_buf[3] = 9;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall.ready", 32'(bus.in_ready),  32'(0));
      chk("stall.valid", 32'(bus.out_valid), 32'(1));
      chk("stall.data",  32'(bus.out_data),  32'(2));
      chk("stall.index", 32'(bus.out_index), 32'(0));
      chk("stall.buf0",  32'(bus.out_buf[0]), 32'(3));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput("release10", 1'b1, 3, 9, 3, 7, 8, 4);

    applyStimulus("evict1", 1, 3, 7, 8, 10);
    checkOutput("evict1", 1'b1, 1, 7, 3, 8, 10, 4);

    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.valid", 32'(bus.out_valid), 32'(0));
    chk("midrst.count", 32'(bus.count),     32'(0));
    chk("midrst.buf1",  32'(bus.out_buf[1]), 32'(M));
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    applyStimulus("refill4a", 4, M, M, M, M);
    checkOutput("refill4a", 1'b0, 3, 0, M, M, M, 1);
    applyStimulus("refill4b", 4, 4, M, M, M);
    checkOutput("refill4b", 1'b0, 3, 0, 4, M, M, 2);
    applyStimulus("refill1", 1, 4, 4, M, M);
    checkOutput("refill1", 1'b0, 3, 0, 4, 4, M, 3);
    applyStimulus("refill4c", 4, 1, 4, 4, M);
    checkOutput("refill4c", 1'b0, 3, 0, 1, 4, 4, 4);

    applyStimulus("dup6", 6, 1, 4, 4, 4);
    checkOutput("dup6", 1'b1, 1, 4, 1, 4, 4, 4);

    applyStimulus("nomatch", 2, 1, 5, 6, 7);
    checkOutput("nomatch", 1'b1, 3, 4, 1, 5, 6, 4);
    chk("nomatch.err", 32'(bus.err), 32'(ERR_EXP));

    applyStimulus("after", 3, 1, 2, 4, 6);
    checkOutput("after", 1'b1, 0, 1, 2, 4, 6, 4);
    chk("after.err", 32'(bus.err), 32'(ERR_EXP));

    repeat (2) @(posedge clk);
    #1;
    chk("idle.valid", 32'(bus.out_valid), 32'(0));
    chk("idle.err",   32'(bus.err),       32'(ERR_EXP));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
